// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
// Bundles the connections between the multicycle control unit and the MIPS
// datapath/memory.
//   Datapath -> controller : op, funct (instruction register fields),
//                            zero (ALU flag), mem_ready (memory handshake)
//   Controller -> datapath : memread, memwrite, iord, irwrite, pcen, pcsrc,
//                            alusrca, alusrcb, zext, aluop, regwrite, regdst,
//                            wdsel, illegal_op, state, instr_count
// The master modport is the controller's view; slave is the datapath's view.
// ---------------------------------------------------------------------------
interface multicycle_controller_if #(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32
);
   logic [5:0]         op;
   logic [5:0]         funct;
   logic               zero;
   logic               mem_ready;

   logic               memread;
   logic               memwrite;
   logic               iord;
   logic               irwrite;
   logic               pcen;
   logic [1:0]         pcsrc;
   logic               alusrca;
   logic [1:0]         alusrcb;
   logic               zext;
   logic [ALUOP_W-1:0] aluop;
   logic               regwrite;
   logic [1:0]         regdst;
   logic [1:0]         wdsel;
   logic               illegal_op;
   logic [3:0]         state;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      input  op, funct, zero, mem_ready,
      output memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             zext, aluop, regwrite, regdst, wdsel, illegal_op, state, instr_count
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
             zext, aluop, regwrite, regdst, wdsel, illegal_op, state, instr_count
   );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
// Moore control FSM for the 32-bit multicycle MIPS datapath. Steps each
// instruction through fetch/decode/execute/memory/writeback, stalls on the
// memory ready handshake, traps unknown opcodes into a sticky ILLEGAL state
// and counts retired instructions.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - multicycle_controller_if.master (IR fields, zero flag,
//              memory handshake in; datapath controls, debug state and
//              retired-instruction count out)
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32
) (
   input logic                      clk,
   input logic                      reset_n,
   multicycle_controller_if.master  bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = '1;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_REXEC   = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_IEXEC   = 4'd9,
      S_IWB     = 4'd10,
      S_JUMP    = 4'd11,
      S_JR      = 4'd12,
      S_JAL     = 4'd13,
      S_ILLEGAL = 4'd14
   } state_t;

   typedef struct packed {
      logic               memread;
      logic               memwrite;
      logic               iord;
      logic [1:0]         pcsrc;
      logic               alusrca;
      logic [1:0]         alusrcb;
      logic               zext;
      logic [ALUOP_W-1:0] aluop;
      logic               regwrite;
      logic [1:0]         regdst;
      logic [1:0]         wdsel;
      logic               illegal;
   } ctrl_t;

   state_t             r_state;
   state_t             w_nextState;
   ctrl_t              r_ctrl;
   logic [CNT_W-1:0]   r_instrCount;
   logic               w_retire;
   logic               w_pcen;

   // Moore output table. Evaluated on the state being entered so the
   // controls come straight out of flops and line up with r_state. The
   // opcode only matters for IEXEC, and it is already stable in DECODE
   // when IEXEC is chosen.
   function automatic ctrl_t decodeState(input state_t s, input logic [5:0] opc);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = 2'b01;
            c.aluop   = ALU_ADD;
         end
         S_DECODE: begin
            c.alusrcb = 2'b11;
            c.aluop   = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.aluop   = ALU_ADD;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.wdsel    = 2'b01;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_REXEC: begin
            c.alusrca = 1'b1;
            c.aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'b01;
         end
         S_BRANCH: begin
            c.alusrca = 1'b1;
            c.aluop   = ALU_SUB;
            c.pcsrc   = 2'b01;
         end
         S_IEXEC: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
            c.zext    = (opc == OP_ORI) || (opc == OP_ANDI);
            if (opc == OP_ORI)
               c.aluop = ALU_OR;
            else if (opc == OP_ANDI)
               c.aluop = ALU_AND;
            else
               c.aluop = ALU_ADD;
         end
         S_IWB: begin
            c.regwrite = 1'b1;
         end
         S_JUMP: begin
            c.pcsrc = 2'b10;
         end
         S_JR: begin
            c.pcsrc = 2'b11;
         end
         S_JAL: begin
            c.pcsrc    = 2'b10;
            c.regwrite = 1'b1;
            c.regdst   = 2'b10;
            c.wdsel    = 2'b10;
         end
         S_ILLEGAL: begin
            c.illegal = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      return c;
   endfunction

   // Next-state logic. Memory states hold until mem_ready; every terminal
   // state of an instruction flags a retire so the counter bumps on the
   // same edge that returns to FETCH. ILLEGAL never leaves on its own.
   always_comb begin
      w_nextState = r_state;
      w_retire    = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (bus.mem_ready)
               w_nextState = S_DECODE;
         end
         S_DECODE: begin
            case (bus.op)
               OP_LW, OP_SW:             w_nextState = S_MEMADR;
               OP_RTYPE:                 w_nextState = (bus.funct == FN_JR) ? S_JR : S_REXEC;
               OP_BEQ, OP_BNE:           w_nextState = S_BRANCH;
               OP_ADDI, OP_ORI, OP_ANDI: w_nextState = S_IEXEC;
               OP_J:                     w_nextState = S_JUMP;
               OP_JAL:                   w_nextState = S_JAL;
               default:                  w_nextState = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            w_nextState = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            if (bus.mem_ready)
               w_nextState = S_MEMWB;
         end
         S_MEMWR: begin
            if (bus.mem_ready) begin
               w_nextState = S_FETCH;
               w_retire    = 1'b1;
            end
         end
         S_REXEC: begin
            w_nextState = S_ALUWB;
         end
         S_IEXEC: begin
            w_nextState = S_IWB;
         end
         S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JR, S_JAL: begin
            w_nextState = S_FETCH;
            w_retire    = 1'b1;
         end
         S_ILLEGAL: begin
            w_nextState = S_ILLEGAL;
         end
         default: begin
            w_nextState = S_ILLEGAL;
         end
      endcase
   end

   // State, registered controls and the retire counter. Reset forces the
   // FETCH output pattern immediately, which also drops any write strobe
   // of an instruction that was still in flight. The counter wraps freely.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_FETCH;
         r_ctrl       <= decodeState(S_FETCH, OP_RTYPE);
         r_instrCount <= '0;
      end else begin
         r_state <= w_nextState;
         r_ctrl  <= decodeState(w_nextState, bus.op);
         if (w_retire)
            r_instrCount <= r_instrCount + 1'b1;
      end
   end

   // The PC and IR enables are the only outputs that look at inputs: they
   // must fall during a memory wait and follow the branch outcome, so they
   // are gated combinationally rather than registered.
   always_comb begin
      w_pcen = 1'b0;
      case (r_state)
         S_FETCH:               w_pcen = bus.mem_ready;
         S_BRANCH:              w_pcen = bus.zero ^ (bus.op == OP_BNE);
         S_JUMP, S_JR, S_JAL:   w_pcen = 1'b1;
         default:               w_pcen = 1'b0;
      endcase
   end

   assign bus.irwrite     = (r_state == S_FETCH) && bus.mem_ready;
   assign bus.pcen        = w_pcen;
   assign bus.memread     = r_ctrl.memread;
   assign bus.memwrite    = r_ctrl.memwrite;
   assign bus.iord        = r_ctrl.iord;
   assign bus.pcsrc       = r_ctrl.pcsrc;
   assign bus.alusrca     = r_ctrl.alusrca;
   assign bus.alusrcb     = r_ctrl.alusrcb;
   assign bus.zext        = r_ctrl.zext;
   assign bus.aluop       = r_ctrl.aluop;
   assign bus.regwrite    = r_ctrl.regwrite;
   assign bus.regdst      = r_ctrl.regdst;
   assign bus.wdsel       = r_ctrl.wdsel;
   assign bus.illegal_op  = r_ctrl.illegal;
   assign bus.state       = r_state;
   assign bus.instr_count = r_instrCount;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
// Directed bench for the multicycle control unit (CNT_W = 4 so the retire
// counter wrap is reachable). Each cycle the driver pushes the expected
// state/control/count vector into a queue; a monitor pops and compares it
// at the falling edge, or immediately when an asynchronous reset check is
// requested through sampleEv.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam int ALUOP_W = 4;
   localparam int CNT_W   = 4;

   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] J    = 6'b000010;
   localparam logic [5:0] JAL  = 6'b000011;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] BNE  = 6'b000101;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] ANDI = 6'b001100;
   localparam logic [5:0] ORI  = 6'b001101;
   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] BAD  = 6'b111111;

   typedef struct {
      string       name;
      logic [28:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic resetN;
   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;
   event sampleEv;

   multicycle_controller_if #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

   multicycle_controller #(.ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (resetN),
      .bus     (bus)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   // Expected control outputs for a state, straight from the state table:
   // {memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
   //  zext, aluop, regwrite, regdst, wdsel, illegal_op}
   function automatic logic [20:0] expCtrl(input int st, input logic [5:0] o,
                                           input logic z, input logic r);
      logic       mr, mw, io, irw, pce, asa, zx, rw, ill;
      logic [1:0] psrc, asb, rd, wd;
      logic [3:0] aop;
      {mr, mw, io, irw, pce, asa, zx, rw, ill} = '0;
      {psrc, asb, rd, wd} = '0;
      aop = 4'd0;
      case (st)
         0:  begin mr = 1; asb = 2'b01; irw = r; pce = r; end
         1:  begin asb = 2'b11; end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; io = 1; end
         4:  begin rw = 1; wd = 2'b01; end
         5:  begin mw = 1; io = 1; end
         6:  begin asa = 1; aop = 4'hF; end
         7:  begin rw = 1; rd = 2'b01; end
         8:  begin asa = 1; aop = 4'd1; psrc = 2'b01; pce = z ^ (o == BNE); end
         9:  begin
                asa = 1; asb = 2'b10;
                zx  = (o == ORI) || (o == ANDI);
                aop = (o == ORI) ? 4'd3 : ((o == ANDI) ? 4'd2 : 4'd0);
             end
         10: begin rw = 1; end
         11: begin psrc = 2'b10; pce = 1; end
         12: begin psrc = 2'b11; pce = 1; end
         13: begin psrc = 2'b10; pce = 1; rw = 1; rd = 2'b10; wd = 2'b10; end
         14: begin ill = 1; end
         default: begin ill = 1; end
      endcase
      return {mr, mw, io, irw, pce, psrc, asa, asb, zx, aop, rw, rd, wd, ill};
   endfunction

   function automatic logic [28:0] makeExp(input int st, input logic [5:0] o,
                                           input logic z, input logic r, input int cnt);
      return {4'(st), expCtrl(st, o, z, r), 4'(cnt)};
   endfunction

   // One clock cycle of stimulus: drive just after the rising edge and queue
   // what the controller should be presenting for the rest of that cycle.
   task automatic applyStimulus(input string nm, input logic rstN, input logic [5:0] o,
                                input logic [5:0] f, input logic z, input logic r,
                                input int st, input int cnt);
      exp_t e;
      @(posedge clk);
      #1;
      resetN        = rstN;
      bus.op        = o;
      bus.funct     = f;
      bus.zero      = z;
      bus.mem_ready = r;
      e.name = nm;
      e.exp  = makeExp(st, o, z, r, cnt);
      expQ.push_back(e);
   endtask

   // Whole instruction with memory always ready; every cycle shares the
   // count value from before the retire edge.
   task automatic runInstr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int n, input int seq[6], input int cnt);
      for (int i = 0; i < n; i++)
         applyStimulus($sformatf("%s c%0d", nm, i), 1'b1, o, f, z, 1'b1, seq[i], cnt);
   endtask

   // Scoreboard comparison of one queued vector against the live outputs
   task automatic checkOutput(input exp_t e);
      logic [28:0] act;
      act = {bus.state, bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pcen,
             bus.pcsrc, bus.alusrca, bus.alusrcb, bus.zext, bus.aluop, bus.regwrite,
             bus.regdst, bus.wdsel, bus.illegal_op, bus.instr_count};
      vectors++;
      if (act !== e.exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h (state %0d cnt %0d) expected %h (state %0d cnt %0d)",
                  e.name, act, act[28:25], act[3:0], e.exp, e.exp[28:25], e.exp[3:0]);
      end
   endtask

   // Monitor: consumes expectations independently of the driver
   initial begin
      forever begin
         @(negedge clk or sampleEv);
         if (expQ.size() > 0)
            checkOutput(expQ.pop_front());
      end
   end

   // Directed instruction sequence
   initial begin
      exp_t e;
      resetN        = 1'b0;
      bus.op        = RT;
      bus.funct     = 6'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;

      applyStimulus("reset noready", 1'b0, RT, 6'd0, 1'b0, 1'b0, 0, 0);
      applyStimulus("reset ready",   1'b0, LW, 6'd0, 1'b0, 1'b1, 0, 0);

      runInstr("lw", LW, 6'd0, 1'b0, 5, '{0, 1, 2, 3, 4, 0}, 0);

      applyStimulus("sw fetch wait", 1'b1, SW, 6'd0, 1'b0, 1'b0, 0, 1);
      applyStimulus("sw fetch",      1'b1, SW, 6'd0, 1'b0, 1'b1, 0, 1);
      applyStimulus("sw decode",     1'b1, SW, 6'd0, 1'b0, 1'b0, 1, 1);
      applyStimulus("sw memadr",     1'b1, SW, 6'd0, 1'b0, 1'b0, 2, 1);
      for (int i = 0; i < 3; i++)
         applyStimulus($sformatf("sw memwr wait%0d", i), 1'b1, SW, 6'd0, 1'b0, 1'b0, 5, 1);
      applyStimulus("sw memwr ready", 1'b1, SW, 6'd0, 1'b0, 1'b1, 5, 1);

      runInstr("beq z1",  BEQ,  6'd0,      1'b1, 3, '{0, 1, 8, 0, 0, 0}, 2);
      runInstr("bne z1",  BNE,  6'd0,      1'b1, 3, '{0, 1, 8, 0, 0, 0}, 3);
      runInstr("bne z0",  BNE,  6'd0,      1'b0, 3, '{0, 1, 8, 0, 0, 0}, 4);
      runInstr("add",     RT,   6'b100000, 1'b0, 4, '{0, 1, 6, 7, 0, 0}, 5);
      runInstr("jr",      RT,   6'b001000, 1'b0, 3, '{0, 1, 12, 0, 0, 0}, 6);
      runInstr("jal",     JAL,  6'd0,      1'b0, 3, '{0, 1, 13, 0, 0, 0}, 7);
      runInstr("j",       J,    6'd0,      1'b0, 3, '{0, 1, 11, 0, 0, 0}, 8);
      runInstr("ori",     ORI,  6'd0,      1'b0, 4, '{0, 1, 9, 10, 0, 0}, 9);
      runInstr("andi",    ANDI, 6'd0,      1'b0, 4, '{0, 1, 9, 10, 0, 0}, 10);
      runInstr("addi",    ADDI, 6'd0,      1'b0, 4, '{0, 1, 9, 10, 0, 0}, 11);

      runInstr("bad", BAD, 6'd0, 1'b0, 2, '{0, 1, 0, 0, 0, 0}, 12);
      for (int i = 0; i < 20; i++)
         applyStimulus($sformatf("illegal hold%0d", i), 1'b1, BAD, 6'd0, 1'b0,
                       1'(i % 2), 14, 12);
      applyStimulus("illegal reset", 1'b0, ADDI, 6'd0, 1'b0, 1'b1, 0, 0);

      for (int k = 0; k < 17; k++)
         runInstr($sformatf("wrap addi%0d", k), ADDI, 6'd0, 1'b0, 4,
                  '{0, 1, 9, 10, 0, 0}, k % 16);
      runInstr("after wrap", ADDI, 6'd0, 1'b0, 4, '{0, 1, 9, 10, 0, 0}, 1);

      @(negedge clk);
      #2;
      resetN = 1'b0;
      #1;
      e.name = "iwb async reset";
      e.exp  = makeExp(0, ADDI, 1'b0, 1'b1, 0);
      expQ.push_back(e);
      ->sampleEv;
      #1;
      applyStimulus("iwb reset held", 1'b0, ADDI, 6'd0, 1'b0, 1'b1, 0, 0);
      applyStimulus("post reset fetch", 1'b1, ADDI, 6'd0, 1'b0, 1'b1, 0, 0);
      applyStimulus("post reset decode", 1'b1, ADDI, 6'd0, 1'b0, 1'b1, 1, 0);

      @(posedge clk);
      @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
